sequence_generator: RTL and testbench
=====================================

// Module: sequence_generator
// PURPOSE
//  Serial pattern transmitter for the 01[0*]1 sequence detector: emits framed bit streams
//  0,1,0^k,1 (k programmable) on sig_out, one bit per ena-qualified clk, with idle gap bits
//  between frames. Counts frames sent and shows the count mod 100 on two 7-seg digits.
//  Sits upstream of the detector as its on-chip stimulus source / loopback partner.
// PARAMETERS
//  ZW          4   width of zeros input; max middle-zero count 2^ZW-1
//  GAP_BITS    2   idle bits inserted after every frame's final 1 (0 allowed)
//  IDLE_LEVEL  1   sig_out level during IDLE and gap bits
// PORTS
//  clk        in   1     system clock, all state on posedge
//  rst        in   1     reset; synchronous, active-high
//  ena        in   1     bit strobe; FSM/counters advance only when high
//  start      in   1     begin transmission; sampled only in IDLE
//  stop       in   1     end continuous/counted run after current frame+gap
//  zeros      in   ZW    middle-zero count k, captured at start
//  frames     in   8     frames to send, captured at start; 0 = continuous
//  sig_out    out  1     serial bit stream (registered)
//  busy       out  1     high from start accept until done
//  frame_end  out  1     comb: state==LAST & ena (final 1 being consumed)
//  done       out  1     1-clk pulse when run completes
//  disp0      out  7     7-seg ones digit of frames-sent, active-low {g..a}
//  disp1      out  7     7-seg tens digit, same encoding
// BEHAVIOUR
//  - Reset: state IDLE, sig_out=IDLE_LEVEL, busy=0, done=0, counters 0, disp0=disp1=7'b1000000.
//  - Reset mid-run aborts immediately; no done pulse; display returns to 00.
//  - States: IDLE, LEAD0(bit 0), ONE(bit 1), MID(bit 0, k cycles), LAST(bit 1), GAP(IDLE_LEVEL,
//    GAP_BITS cycles). sig_out takes the new state's bit on the edge entering it.
//  - IDLE: start=1 (ena irrelevant) -> next edge LEAD0, busy=1, latch zeros/frames, clear stop flag.
//  - Transitions out of LEAD0/ONE/MID/LAST/GAP occur only on edges with ena=1:
//    LEAD0->ONE; ONE->MID if k>0 else LAST; MID->LAST after k ena cycles; LAST->GAP (or
//    end-of-frame decision if GAP_BITS=0); GAP->end-of-frame decision after GAP_BITS ena cycles.
//  - End-of-frame decision: if stop_flag or (frames!=0 and sent==frames) -> IDLE, done=1 one clk,
//    busy=0, sig_out=IDLE_LEVEL; else -> LEAD0 of next frame (no extra idle cycle).
//  - ena=0: state, sig_out, counters frozen; each bit lasts exactly one ena-high cycle.
//  - Frame length 3+k bits; period 3+k+GAP_BITS ena cycles. k=0 -> frame 0,1,1.
//  - stop: any clk while busy sets stop_flag; current frame and gap always complete.
//    stop in IDLE ignored. start while busy ignored. start and stop together in IDLE: start wins.
//  - Frame counter: 8-bit run counter 'sent' increments on LAST&ena (stops count for frames!=0).
//    Display counter: two BCD digits, +1 on LAST&ena, 99->00 wrap; cleared only by rst,
//    accumulates across runs. No divide/modulo hardware.
//  - disp0/disp1 registered from BCD every clk (not ena-gated), one clk after count change.
//    Codes 0-9: 1000000,1111001,0100100,0110000,0011001,0010010,0000010,1111000,0000000,0011000.
// TESTING
//  1. rst; ena=1; zeros=2, frames=1, start -> sig_out 0,1,0,0,1,1,1 then done pulse,
//     busy=0, disp0=1111001, disp1=1000000.
//  2. zeros=0, frames=3 -> 0,1,1,1,1 x3; exactly 3 frame_end pulses; disp0=0110000.
//  3. Repeat test 1 with ena toggling 1,0,1,0 -> same bit sequence, each bit held 2 clk.
//  4. frames=0, zeros=3; assert stop during MID of frame 5 -> frame 5 and gap finish,
//     done once, display 05; stop pulse in IDLE -> no effect.
//  5. 101 frames total, zeros=1 -> display wraps: disp1=1000000, disp0=1111001 (01).
//  6. rst during MID -> next clk sig_out=1, busy=0, disp=00; start pulsed while busy -> no restart,
//     zeros changed while busy -> current frame length unchanged.

Source files
------------

// File: rtl/sequence_generator.sv
// -----------------------------------------------------------------------------
// sequence_generator
//   Serial pattern transmitter feeding the 01[0*]1 sequence detector. Each frame
//   is the bit string 0,1,0^k,1 followed by GAP_BITS idle bits. One bit is sent
//   per ena-qualified clock. The number of frames sent is shown mod 100 on two
//   active-low 7-segment digits.
//
// Parameters
//   ZW          width of zeros input (max middle-zero count 2^ZW-1)
//   GAP_BITS    idle bits after each frame's final 1 (0 allowed)
//   IDLE_LEVEL  sig_out level during IDLE and gap bits
//
// Ports
//   clk        in   system clock, all state on posedge
//   rst        in   synchronous active-high reset
//   ena        in   bit strobe; sequencing advances only when high
//   start      in   begin a run (sampled only in IDLE)
//   stop       in   end the run after the current frame and gap
//   zeros      in   middle-zero count k, captured at start
//   frames     in   frames to send, captured at start; 0 = continuous
//   sig_out    out  registered serial bit stream
//   busy       out  high from start accept until the run completes
//   frame_end  out  combinational: final 1 of a frame being consumed
//   done       out  one-clock pulse when the run completes
//   disp0      out  ones digit of frames-sent count, {g..a} active-low
//   disp1      out  tens digit, same encoding
// -----------------------------------------------------------------------------
module sequence_generator #(
  parameter int   ZW         = 4,
  parameter int   GAP_BITS   = 2,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          start,
  input  logic          stop,
  input  logic [ZW-1:0] zeros,
  input  logic [7:0]    frames,
  output logic          sig_out,
  output logic          busy,
  output logic          frame_end,
  output logic          done,
  output logic [6:0]    disp0,
  output logic [6:0]    disp1
);

  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD0,
    S_ONE,
    S_MID,
    S_LAST,
    S_GAP
  } state_t;

  state_t          r_state;
  logic            r_sig_out;
  logic            r_busy;
  logic            r_done;
  logic [ZW-1:0]   r_k;
  logic [7:0]      r_frames;
  logic [7:0]      r_sent;
  logic [ZW-1:0]   r_mid_cnt;
  logic [GW-1:0]   r_gap_cnt;
  logic            r_stop_flag;
  logic [3:0]      r_bcd0;
  logic [3:0]      r_bcd1;
  logic [6:0]      r_disp0;
  logic [6:0]      r_disp1;

  logic            w_frame_end;
  logic            w_gap_last;
  logic            w_eof;
  logic [7:0]      w_sent_after;
  logic            w_run_over;

  // 7-segment code, active-low, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0011000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign w_frame_end = (r_state == S_LAST) & ena;
  assign w_gap_last  = (r_gap_cnt == GW'(GAP_BITS - 1));

  // End-of-frame decision point: leaving GAP after its last bit, or leaving
  // LAST directly when there is no gap.
  assign w_eof = ena & (((r_state == S_LAST) & (GAP_BITS == 0)) |
                        ((r_state == S_GAP)  & w_gap_last));

  // When GAP_BITS is 0 the decision coincides with the LAST edge, so the
  // frame being completed must be included in the comparison.
  assign w_sent_after = r_sent + {7'd0, w_frame_end};
  assign w_run_over   = r_stop_flag | stop |
                        ((r_frames != 8'd0) & (w_sent_after == r_frames));

  // NOTE: every clocked register uses non-blocking assignment so all state
  // updates see pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sig_out   <= IDLE_LEVEL;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_k         <= '0;
      r_frames    <= '0;
      r_sent      <= '0;
      r_mid_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_stop_flag <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (r_busy && stop) begin
        r_stop_flag <= 1'b1;
      end

      if (w_frame_end) begin
        r_sent <= r_sent + 8'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_LEAD0;
            r_sig_out   <= 1'b0;
            r_busy      <= 1'b1;
            r_k         <= zeros;
            r_frames    <= frames;
            r_sent      <= '0;
            r_stop_flag <= 1'b0;
          end
        end
        S_LEAD0: begin
          if (ena) begin
            r_state   <= S_ONE;
            r_sig_out <= 1'b1;
          end
        end
        S_ONE: begin
          if (ena) begin
            if (r_k != '0) begin
              r_state   <= S_MID;
              r_sig_out <= 1'b0;
              r_mid_cnt <= '0;
            end else begin
              r_state   <= S_LAST;
              r_sig_out <= 1'b1;
            end
          end
        end
        S_MID: begin
          if (ena) begin
            if (r_mid_cnt == r_k - ZW'(1)) begin
              r_state   <= S_LAST;
              r_sig_out <= 1'b1;
            end else begin
              r_mid_cnt <= r_mid_cnt + ZW'(1);
            end
          end
        end
        S_LAST: begin
          // With no gap the decision block below takes over this edge.
          if (ena && (GAP_BITS != 0)) begin
            r_state   <= S_GAP;
            r_sig_out <= IDLE_LEVEL;
            r_gap_cnt <= '0;
          end
        end
        S_GAP: begin
          if (ena && !w_gap_last) begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_sig_out <= IDLE_LEVEL;
          r_busy    <= 1'b0;
        end
      endcase

      // Overrides the per-state next value on the frame's final edge.
      if (w_eof) begin
        if (w_run_over) begin
          r_state   <= S_IDLE;
          r_sig_out <= IDLE_LEVEL;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
        end else begin
          r_state   <= S_LEAD0;
          r_sig_out <= 1'b0;
        end
      end
    end
  end

  // Frames-sent display: BCD counter accumulates across runs and is cleared
  // only by reset. Segment outputs follow the BCD value one clock later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcd0  <= '0;
      r_bcd1  <= '0;
      r_disp0 <= 7'b1000000;
      r_disp1 <= 7'b1000000;
    end else begin
      if (w_frame_end) begin
        if (r_bcd0 == 4'd9) begin
          r_bcd0 <= 4'd0;
          r_bcd1 <= (r_bcd1 == 4'd9) ? 4'd0 : r_bcd1 + 4'd1;
        end else begin
          r_bcd0 <= r_bcd0 + 4'd1;
        end
      end
      r_disp0 <= seg7(r_bcd0);
      r_disp1 <= seg7(r_bcd1);
    end
  end

  assign sig_out   = r_sig_out;
  assign busy      = r_busy;
  assign done      = r_done;
  assign frame_end = w_frame_end;
  assign disp0     = r_disp0;
  assign disp1     = r_disp1;

endmodule

// File: tb/tb_sequence_generator.sv
// -----------------------------------------------------------------------------
// tb_sequence_generator
//   Self-checking bench for sequence_generator. A reference model describes the
//   transmitter as "position within the current frame's bit list" plus run
//   bookkeeping; every clock the DUT outputs are compared with it. Directed
//   scenarios are followed by randomized runs.
// -----------------------------------------------------------------------------
module tb_sequence_generator;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       start;
  logic       stop;
  logic [3:0] zeros;
  logic [7:0] frames;
  logic       sig_out;
  logic       busy;
  logic       frame_end;
  logic       done;
  logic [6:0] disp0;
  logic [6:0] disp1;

  sequence_generator #(
    .ZW         (4),
    .GAP_BITS   (GAP),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .start     (start),
    .stop      (stop),
    .zeros     (zeros),
    .frames    (frames),
    .sig_out   (sig_out),
    .busy      (busy),
    .frame_end (frame_end),
    .done      (done),
    .disp0     (disp0),
    .disp1     (disp1)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  bit m_valid = 1'b0;
  bit m_busy, m_done, m_sig, m_stop;
  int m_pos, m_k, m_nframes, m_sent, m_total, m_disp_cnt;

  // Observation helpers.
  logic q_sig[$];
  int   fe_count;
  int   done_count;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'b1000000;
      1: seg = 7'b1111001;
      2: seg = 7'b0100100;
      3: seg = 7'b0110000;
      4: seg = 7'b0011001;
      5: seg = 7'b0010010;
      6: seg = 7'b0000010;
      7: seg = 7'b1111000;
      8: seg = 7'b0000000;
      default: seg = 7'b0011000;
    endcase
  endfunction

  // Bit at position p of a frame 0,1,0^k,1 followed by idle-level gap bits.
  function automatic bit bit_at(input int p, input int k);
    if (p == 0)          bit_at = 1'b0;
    else if (p == 1)     bit_at = 1'b1;
    else if (p < 2 + k)  bit_at = 1'b0;
    else if (p == 2 + k) bit_at = 1'b1;
    else                 bit_at = 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_edge();
    if (rst) begin
      m_valid    = 1'b1;
      m_busy     = 1'b0;
      m_done     = 1'b0;
      m_sig      = 1'b1;
      m_stop     = 1'b0;
      m_pos      = 0;
      m_k        = 0;
      m_nframes  = 0;
      m_sent     = 0;
      m_total    = 0;
      m_disp_cnt = 0;
      return;
    end
    m_done     = 1'b0;
    m_disp_cnt = m_total;
    if (!m_busy) begin
      if (start) begin
        m_busy    = 1'b1;
        m_pos     = 0;
        m_k       = int'(zeros);
        m_nframes = int'(frames);
        m_sent    = 0;
        m_stop    = 1'b0;
        m_sig     = 1'b0;
      end
    end else begin
      if (stop) m_stop = 1'b1;
      if (ena) begin
        if (m_pos == 2 + m_k) begin
          m_sent  = (m_sent + 1) % 256;
          m_total = (m_total + 1) % 100;
        end
        m_pos++;
        if (m_pos == 3 + m_k + GAP) begin
          if (m_stop || (m_nframes != 0 && m_sent == m_nframes)) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_sig  = 1'b1;
          end else begin
            m_pos = 0;
            m_sig = 1'b0;
          end
        end else begin
          m_sig = bit_at(m_pos, m_k);
        end
      end
    end
  endtask

  // One clock: check frame_end before the edge, outputs #1 after it, then
  // return at the falling edge ready for the next input change.
  task automatic tick();
    #1;
    if (m_valid)
      chk("frame_end", {7'd0, frame_end},
          {7'd0, (m_busy && ena && (m_pos == 2 + m_k))});
    if (frame_end === 1'b1) fe_count++;
    @(posedge clk);
    model_edge();
    #1;
    if (m_valid) begin
      chk("sig_out", {7'd0, sig_out}, {7'd0, m_sig});
      chk("busy",    {7'd0, busy},    {7'd0, m_busy});
      chk("done",    {7'd0, done},    {7'd0, m_done});
      chk("disp0",   {1'b0, disp0},   {1'b0, seg(m_disp_cnt % 10)});
      chk("disp1",   {1'b0, disp1},   {1'b0, seg(m_disp_cnt / 10)});
    end
    q_sig.push_back(sig_out);
    if (done === 1'b1) done_count++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic start_run(input int k, input int n);
    zeros  = 4'(k);
    frames = 8'(n);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // ena_mode: 0 = always high, 1 = toggling 0,1,0,1..., 2 = random with
  // occasional stop, start and zeros noise.
  task automatic run_until_done(input string tag, input int bound, input int ena_mode);
    int n = 0;
    while (n < bound) begin
      case (ena_mode)
        0:       ena = 1'b1;
        1:       ena = n[0];
        default: begin
          ena   = ($urandom_range(0, 3) != 0);
          stop  = ($urandom_range(0, 59) == 0);
          start = ($urandom_range(0, 9) == 0);
          zeros = 4'($urandom_range(0, 15));
        end
      endcase
      tick();
      n++;
      if (done === 1'b1) break;
    end
    stop  = 1'b0;
    start = 1'b0;
    ena   = 1'b1;
    chk(tag, {7'd0, done}, 8'd1);
  endtask

  bit exp1[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    rst    = 1'b0;
    ena    = 1'b1;
    start  = 1'b0;
    stop   = 1'b0;
    zeros  = '0;
    frames = '0;
    fe_count   = 0;
    done_count = 0;
    @(negedge clk);

    // Reset state.
    do_reset();
    chk("rst_sig",   {7'd0, sig_out}, 8'd1);
    chk("rst_busy",  {7'd0, busy},    8'd0);
    chk("rst_disp0", {1'b0, disp0},   8'b01000000);
    chk("rst_disp1", {1'b0, disp1},   8'b01000000);

    // Single frame, k=2.
    q_sig.delete();
    start_run(2, 1);
    run_until_done("t1_done", 30, 0);
    chk("t1_len", 8'(q_sig.size()), 8'd8);
    for (int i = 0; i < 7; i++) chk($sformatf("t1_bit%0d", i), {7'd0, q_sig[i]}, {7'd0, exp1[i]});
    chk("t1_busy",  {7'd0, busy}, 8'd0);
    chk("t1_disp0", {1'b0, disp0}, 8'b01111001);
    chk("t1_disp1", {1'b0, disp1}, 8'b01000000);

    // Three frames, k=0: exactly three frame_end pulses.
    do_reset();
    fe_count = 0;
    start_run(0, 3);
    run_until_done("t2_done", 60, 0);
    tick();
    chk("t2_fe_count", 8'(fe_count), 8'd3);
    chk("t2_disp0", {1'b0, disp0}, 8'b00110000);

    // Test 1 again with ena toggling: each bit held two clocks.
    do_reset();
    q_sig.delete();
    start_run(2, 1);
    run_until_done("t3_done", 60, 1);
    chk("t3_len", 8'(q_sig.size()), 8'd15);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("t3_bit%0da", i), {7'd0, q_sig[2*i]},   {7'd0, exp1[i]});
      chk($sformatf("t3_bit%0db", i), {7'd0, q_sig[2*i+1]}, {7'd0, exp1[i]});
    end
    chk("t3_disp0", {1'b0, disp0}, 8'b01111001);

    // Continuous run, stop during MID of frame 5.
    do_reset();
    start_run(3, 0);
    for (int n = 0; n < 200 && !(m_sent == 4 && m_pos == 3); n++) tick();
    chk("t4_in_mid", {7'd0, sig_out}, 8'd0);
    done_count = 0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    run_until_done("t4_done", 40, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("t4_done_once", 8'(done_count), 8'd1);
    chk("t4_disp0", {1'b0, disp0}, 8'b00010010);
    chk("t4_disp1", {1'b0, disp1}, 8'b01000000);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_idle_stop", {7'd0, busy}, 8'd0);

    // 101 frames: display wraps to 01.
    do_reset();
    start_run(1, 101);
    run_until_done("t5_done", 800, 0);
    tick();
    chk("t5_disp1", {1'b0, disp1}, 8'b01000000);
    chk("t5_disp0", {1'b0, disp0}, 8'b01111001);

    // Start and zeros change while busy, then reset during MID.
    do_reset();
    start_run(3, 0);
    start = 1'b1;
    zeros = 4'd9;
    tick();
    start = 1'b0;
    for (int n = 0; n < 20 && m_pos != 3; n++) tick();
    chk("t6_in_mid", {7'd0, sig_out}, 8'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_sig",   {7'd0, sig_out}, 8'd1);
    chk("t6_busy",  {7'd0, busy},    8'd0);
    chk("t6_disp0", {1'b0, disp0},   8'b01000000);
    chk("t6_disp1", {1'b0, disp1},   8'b01000000);

    // Randomized runs with random ena, stop and busy-time noise.
    for (int r = 0; r < 8; r++) begin
      start_run($urandom_range(0, 6), (r == 7) ? 0 : $urandom_range(1, 4));
      if (r == 7) begin
        for (int i = 0; i < 40; i++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
      end
      run_until_done($sformatf("rand%0d_done", r), 400, 2);
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
